// File: rtl/id_ex_control_pkg.sv
// mips_defs: opcode/funct/ALUOp constants and the ID/EX control vector shared by decode and pipeline.
package mips_defs;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [5:0] funct;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       mem_to_reg;
    logic       reg_write;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
  function automatic logic legal_funct(input logic [5:0] f);
    return f == F_ADD || f == F_SUB || f == F_AND || f == F_OR || f == F_SLT;
  endfunction
endpackage

// File: rtl/id_ex_control_main_decoder.sv
// main_decoder: combinational opcode/funct decode into the control vector plus an illegal flag.
module main_decoder
  import mips_defs::*;
#(
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic [31:0] id_instr,
  output ctrl_t       ctrl,
  output logic        illegal
);
  logic [5:0] op;
  logic [5:0] fn;
  assign op = id_instr[31:26];
  assign fn = id_instr[5:0];
  always_comb begin
    ctrl = BUBBLE;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        illegal = !legal_funct(fn);
        ctrl.reg_dst = !illegal;
        ctrl.reg_write = !illegal;
        ctrl.alu_op = illegal ? ALUOP_ADD : ALUOP_FUNCT;
        ctrl.funct = illegal ? 6'd0 : fn;
      end
      OP_LW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_ADDI: begin
        illegal = !SUPPORT_ADDI;
        ctrl.alu_src = SUPPORT_ADDI;
        ctrl.reg_write = SUPPORT_ADDI;
      end
      OP_J: ctrl.jump = 1'b1;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/id_ex_control.sv
// id_ex_control: decode stage control plus the control half of the ID/EX register with stall/flush.
module id_ex_control
  import mips_defs::*;
#(
  parameter bit SUPPORT_ADDI = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  output logic        ex_valid,
  output logic        ex_illegal,
  output logic        ex_RegDst,
  output logic        ex_ALUSrc,
  output logic [1:0]  ex_ALUOp,
  output logic [5:0]  ex_funct,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic        ex_Branch,
  output logic        ex_Jump,
  output logic        ex_MemtoReg,
  output logic        ex_RegWrite
);
  ctrl_t dec;
  ctrl_t ex;
  logic  dec_illegal;
  main_decoder #(.SUPPORT_ADDI(SUPPORT_ADDI)) u_dec (
    .id_instr(id_instr),
    .ctrl    (dec),
    .illegal (dec_illegal)
  );
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ex <= BUBBLE;
      ex_valid <= 1'b0;
      ex_illegal <= 1'b0;
    end else if (!stall) begin
      ex <= id_valid ? dec : BUBBLE;
      ex_valid <= id_valid;
      ex_illegal <= id_valid && dec_illegal;
    end
  end
  assign ex_RegDst   = ex.reg_dst;
  assign ex_ALUSrc   = ex.alu_src;
  assign ex_ALUOp    = ex.alu_op;
  assign ex_funct    = ex.funct;
  assign ex_MemRead  = ex.mem_read;
  assign ex_MemWrite = ex.mem_write;
  assign ex_Branch   = ex.branch;
  assign ex_Jump     = ex.jump;
  assign ex_MemtoReg = ex.mem_to_reg;
  assign ex_RegWrite = ex.reg_write;
endmodule
